// File: rtl/audio_i2s_tx_pkg.sv
// Shared constants, divider taps and sample types for the I2S transmitter.
// Both the top level and the bench import this package.
package audio_i2s_tx_pkg;

   localparam int DEF_SAMPLE_W   = 16;
   localparam int DEF_FIFO_DEPTH = 4;

   // Free-running timebase: one 1024-cycle count is one stereo frame.
   localparam int CNT_W    = 10;
   localparam int MCLK_BIT = 1;
   localparam int SCLK_BIT = 3;
   localparam int LRCK_BIT = 9;
   localparam int SLOT_LSB = 4;
   localparam int SLOT_MSB = 8;

   typedef struct packed {
      logic [DEF_SAMPLE_W-1:0] left;
      logic [DEF_SAMPLE_W-1:0] right;
   } stereo_t;

   // Slot position 0 is the one-bit I2S delay; positions past the sample width are padding.
   function automatic logic is_data_slot(input logic [4:0] pos, input int width);
      return (pos != 5'd0) && (int'(pos) <= width);
   endfunction

endpackage

// File: rtl/audio_i2s_tx_fifo.sv
// Small synchronous FIFO for stereo sample words.
// The read word is combinational, so a pop consumes it in the same cycle.
module audio_sample_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_q, wr_d;
   logic [AW:0]       rd_q, rd_d;
   logic              push_ok;
   logic              pop_ok;

   // The extra pointer bit separates full from empty when the indices match.
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign push_ok = push_i && !full_o && !flush_i;
   assign pop_ok  = pop_i && !empty_o && !flush_i;
   assign rdata_o = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + (AW+1)'(1);
         if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter driven by the audio PLL clock.
// Clocks, frame timing and serial data are all derived from one 10-bit counter.
module audio_i2s_tx
   import audio_i2s_tx_pkg::*;
#(
   parameter int SAMPLE_W   = DEF_SAMPLE_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                clk_audio,
   input  logic                reset_n,
   input  logic                pll_locked,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   output logic                audio_mclk,
   output logic                audio_sclk,
   output logic                audio_lrck,
   output logic                audio_dac,
   output logic [7:0]          underrun_cnt
);

   logic                  sync1_q, sync2_q;
   logic                  running;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  mclk_q, sclk_q, lrck_q;
   logic                  dac_q, dac_d;
   logic [SAMPLE_W-1:0]   left_q, left_d;
   logic [SAMPLE_W-1:0]   right_q, right_d;
   logic [7:0]            und_q, und_d;
   logic                  frame_load;
   logic                  bit_edge;
   logic                  slot_right;
   logic [4:0]            slot_pos;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [2*SAMPLE_W-1:0] fifo_rdata;

   assign running = sync2_q;

   // Everything below is decoded from the next count so registered outputs line up with cnt_q.
   assign cnt_d      = running ? cnt_q + CNT_W'(1) : '0;
   assign frame_load = running && (cnt_q == '1);
   assign bit_edge   = (cnt_d[SCLK_BIT:0] == '0);
   assign slot_pos   = cnt_d[SLOT_MSB:SLOT_LSB];
   assign slot_right = cnt_d[LRCK_BIT];

   assign s_ready   = running && !fifo_full;
   assign fifo_push = s_valid && s_ready;
   assign fifo_pop  = frame_load && !fifo_empty;

   audio_sample_fifo #(
      .DATA_W (2*SAMPLE_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_audio),
      .rst_ni  (reset_n),
      .flush_i (!running),
      .push_i  (fifo_push),
      .wdata_i ({s_left, s_right}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      left_d  = left_q;
      right_d = right_q;
      dac_d   = dac_q;
      und_d   = und_q;
      if (!running) begin
         left_d  = '0;
         right_d = '0;
         dac_d   = 1'b0;
      end else begin
         if (frame_load) begin
            if (!fifo_empty) begin
               left_d  = fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
               right_d = fifo_rdata[SAMPLE_W-1:0];
            end else begin
               left_d  = '0;
               right_d = '0;
               if (und_q != 8'hFF) und_d = und_q + 8'd1;
            end
         end
         // A load always coincides with slot 0, so it never collides with a shift.
         if (bit_edge) begin
            dac_d = 1'b0;
            if (is_data_slot(slot_pos, SAMPLE_W)) begin
               if (slot_right) begin
                  dac_d   = right_q[SAMPLE_W-1];
                  right_d = right_q << 1;
               end else begin
                  dac_d  = left_q[SAMPLE_W-1];
                  left_d = left_q << 1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_audio or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         mclk_q  <= 1'b0;
         sclk_q  <= 1'b0;
         lrck_q  <= 1'b0;
         dac_q   <= 1'b0;
         left_q  <= '0;
         right_q <= '0;
         und_q   <= '0;
      end else begin
         sync1_q <= pll_locked;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         mclk_q  <= cnt_d[MCLK_BIT];
         sclk_q  <= cnt_d[SCLK_BIT];
         lrck_q  <= cnt_d[LRCK_BIT];
         dac_q   <= dac_d;
         left_q  <= left_d;
         right_q <= right_d;
         und_q   <= und_d;
      end
   end

   assign audio_mclk   = mclk_q;
   assign audio_sclk   = sclk_q;
   assign audio_lrck   = lrck_q;
   assign audio_dac    = dac_q;
   assign underrun_cnt = und_q;

endmodule
